// File: rtl/servo_pose_sequencer.sv
// N-channel servo pose engine: tick-rate jogging, pose recording into a small memory,
// and rate-limited replay with per-pose dwell and optional looping.
module servo_pose_sequencer #(
  parameter int N_CH       = 4,
  parameter int W          = 13,
  parameter int DEPTH      = 16,
  parameter int MIN_POS    = 500,
  parameter int MAX_POS    = 2500,
  parameter int CENTER     = 1500,
  parameter int STEP       = 8,
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 100,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH-1:0]   i_jog_inc,
  input  logic [N_CH-1:0]   i_jog_dec,
  input  logic              i_save,
  input  logic              i_clear,
  input  logic              i_play,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic [N_CH*W-1:0] o_servo,
  output logic              o_replaying,
  output logic [AW:0]       o_tot_state,
  output logic [AW-1:0]     o_current_state,
  output logic              o_full
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int W1  = W + 1;
  localparam int AW1 = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic signed [W:0] STEP_S   = W1'(STEP);
  localparam logic signed [W:0] MIN_S    = W1'(MIN_POS);
  localparam logic signed [W:0] MAX_S    = W1'(MAX_POS);
  localparam logic [W-1:0]      CENTER_W = W'(CENTER);
  localparam logic [AW:0]       DEPTH_T  = AW1'(DEPTH);

  logic [1:0]        state, state_nxt;
  logic              replaying;
  logic [CW-1:0]     tick_cnt;
  logic              tick;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [AW:0]       tot, tot_nxt;
  logic [AW-1:0]     cur, cur_nxt;
  logic [N_CH*W-1:0] pos, pos_nxt, target;
  logic [N_CH*W-1:0] mem [DEPTH];
  logic              at_target, full, save_en;

  // Arithmetic runs one bit wider than a position so saturation never sees a wrap.
  function automatic logic [W-1:0] clamp_pos(input logic signed [W:0] v);
    if (v > MAX_S) return MAX_S[W-1:0];
    if (v < MIN_S) return MIN_S[W-1:0];
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] jog_step(input logic [W-1:0] p, input logic up,
                                            input logic dn);
    logic signed [W:0] s;
    s = signed'({1'b0, p});
    if (up && !dn)      s = s + STEP_S;
    else if (dn && !up) s = s - STEP_S;
    return clamp_pos(s);
  endfunction

  function automatic logic [W-1:0] ramp_step(input logic [W-1:0] p, input logic [W-1:0] t);
    logic signed [W:0] s, d;
    s = signed'({1'b0, p});
    d = signed'({1'b0, t}) - s;
    if (d <= STEP_S && d >= -STEP_S) return t;
    if (!d[W]) return clamp_pos(s + STEP_S);
    return clamp_pos(s - STEP_S);
  endfunction

  assign tick   = (tick_cnt == CW'(TICK_DIV - 1));
  assign target = mem[cur];
  assign full   = (tot == DEPTH_T);

  always_comb begin
    pos_nxt   = pos;
    at_target = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (pos[k*W +: W] != target[k*W +: W]) at_target = 1'b0;
      if (tick && state == S_IDLE)
        pos_nxt[k*W +: W] = jog_step(pos[k*W +: W], i_jog_inc[k], i_jog_dec[k]);
      else if (tick && state == S_MOVE && !i_stop)
        pos_nxt[k*W +: W] = ramp_step(pos[k*W +: W], target[k*W +: W]);
    end
  end

  always_comb begin
    state_nxt = state;
    tot_nxt   = tot;
    cur_nxt   = cur;
    hold_nxt  = hold_cnt;
    save_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_clear) begin
          tot_nxt = '0;
        end else if (i_save && !full) begin
          tot_nxt = tot + AW1'(1);
          save_en = 1'b1;
        end
        // Play sees the post-save/clear count so a same-cycle save is included.
        if (i_play && !i_stop && tot_nxt != '0) begin
          cur_nxt   = '0;
          state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        if (i_stop) begin
          state_nxt = S_IDLE;
        end else if (at_target) begin
          hold_nxt  = HW'(HOLD_TICKS);
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_stop) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (hold_cnt <= HW'(1)) begin
            hold_nxt = '0;
            if ({1'b0, cur} + AW1'(1) < tot) begin
              cur_nxt   = cur + AW'(1);
              state_nxt = S_MOVE;
            end else if (i_loop) begin
              cur_nxt   = '0;
              state_nxt = S_MOVE;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            hold_nxt = hold_cnt - HW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      replaying <= 1'b0;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      tot       <= '0;
      cur       <= '0;
      pos       <= {N_CH{CENTER_W}};
    end else begin
      state     <= state_nxt;
      replaying <= (state_nxt != S_IDLE);
      tick_cnt  <= tick ? '0 : tick_cnt + CW'(1);
      hold_cnt  <= hold_nxt;
      tot       <= tot_nxt;
      cur       <= cur_nxt;
      pos       <= pos_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (save_en && !i_rst) mem[tot[AW-1:0]] <= pos;
  end

  assign o_servo         = pos;
  assign o_replaying     = replaying;
  assign o_tot_state     = tot;
  assign o_current_state = cur;
  assign o_full          = full;

endmodule

// File: tb/tb_servo_pose_sequencer.sv
// Directed-plus-random bench for servo_pose_sequencer using a tick-level jog model
// and replay timing derived from the ramp/dwell rules.
module tb_servo_pose_sequencer;

  localparam int N_CH       = 4;
  localparam int W          = 13;
  localparam int DEPTH      = 4;
  localparam int AW         = 2;
  localparam int MIN_POS    = 500;
  localparam int MAX_POS    = 2500;
  localparam int CENTER     = 1500;
  localparam int STEP       = 8;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   jog_inc = '0;
  logic [N_CH-1:0]   jog_dec = '0;
  logic              save = 1'b0, clear = 1'b0, play = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [N_CH*W-1:0] servo;
  logic              replaying;
  logic [AW:0]       tot;
  logic [AW-1:0]     cur;
  logic              full;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int edges = 0;
  int mpos [N_CH];
  bit model_on = 1'b0;
  int frozen;

  servo_pose_sequencer #(
    .N_CH(N_CH), .W(W), .DEPTH(DEPTH), .MIN_POS(MIN_POS), .MAX_POS(MAX_POS),
    .CENTER(CENTER), .STEP(STEP), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_jog_inc(jog_inc), .i_jog_dec(jog_dec),
    .i_save(save), .i_clear(clear), .i_play(play), .i_stop(stop), .i_loop(loop_en),
    .o_servo(servo), .o_replaying(replaying), .o_tot_state(tot),
    .o_current_state(cur), .o_full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int jog_model(input int p, input logic up, input logic dn);
    if (up && !dn) return (p + STEP > MAX_POS) ? MAX_POS : p + STEP;
    if (dn && !up) return (p - STEP < MIN_POS) ? MIN_POS : p - STEP;
    return p;
  endfunction

  function automatic int ch(input int k);
    return int'(servo[k*W +: W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; the jog model advances on every TICK_DIV-th edge after reset release.
  task automatic step();
    logic [N_CH-1:0] ji, jd;
    ji = jog_inc;
    jd = jog_dec;
    @(posedge clk);
    edges++;
    if (model_on && (edges % TICK_DIV == 0))
      for (int k = 0; k < N_CH; k++) mpos[k] = jog_model(mpos[k], ji[k], jd[k]);
    #1;
  endtask

  task automatic next_tick();
    do step(); while (edges % TICK_DIV != 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    edges = 0;
    for (int k = 0; k < N_CH; k++) mpos[k] = CENTER;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < N_CH; k++) chk(tag, ch(k), mpos[k]);
  endtask

  task automatic pulse_save();
    save = 1'b1; step(); save = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1; step(); play = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    for (int k = 0; k < N_CH; k++) chk("rst_center", ch(k), CENTER);
    chk("rst_tot", tot, 0);
    chk("rst_replaying", replaying, 0);
    chk("rst_cur", cur, 0);
    chk("rst_full", full, 0);

    // Jog and saturation
    model_on = 1'b1;
    jog_inc[0] = 1'b1;
    repeat (10 * TICK_DIV) step();
    chk("jog_10_ticks", ch(0), 1580);
    check_model("jog_model_a");
    repeat (200 * TICK_DIV) step();
    chk("jog_sat_max", ch(0), MAX_POS);
    repeat (3 * TICK_DIV) step();
    chk("jog_sat_stays", ch(0), MAX_POS);
    jog_inc[0] = 1'b0;
    jog_dec[0] = 1'b1;
    repeat (2 * TICK_DIV) step();
    chk("jog_dec", ch(0), 2484);
    jog_inc[0] = 1'b1;
    repeat (3 * TICK_DIV) step();
    chk("jog_both_hold", ch(0), 2484);
    jog_inc = '0;
    jog_dec = '0;
    check_model("jog_model_b");

    // Record to full; the fifth save happens with a different ch0 and must be dropped
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        jog_dec[0] = 1'b1;
        repeat (2 * TICK_DIV) step();
        jog_dec[0] = 1'b0;
        chk("pre_fifth_pos", ch(0), 2468);
      end
      pulse_save();
      chk("save_tot", tot, (i > DEPTH) ? DEPTH : i);
      chk("save_full", full, (i >= DEPTH) ? 1 : 0);
    end
    model_on = 1'b0;
    pulse_play();
    chk("full_play_replaying", replaying, 1);
    chk("full_play_cur", cur, 0);
    for (int i = 0; i < 400 && replaying; i++) step();
    chk("full_replay_done", replaying, 0);
    chk("full_mem_kept", ch(0), 2484);
    chk("full_last_cur", cur, DEPTH - 1);
    mpos[0] = 2484;
    model_on = 1'b1;

    // Clear wins over save; play with nothing stored is ignored
    clear = 1'b1; save = 1'b1; step(); clear = 1'b0; save = 1'b0;
    chk("clear_over_save", tot, 0);
    chk("clear_full", full, 0);
    pulse_play();
    chk("play_empty", replaying, 0);

    // Randomized jogging against the tick model
    for (int t = 0; t < 30; t++) begin
      jog_inc = N_CH'($urandom);
      jog_dec = N_CH'($urandom);
      repeat (TICK_DIV) step();
      check_model("rand_jog");
    end
    jog_inc = '0;
    jog_dec = '0;

    // Replay ramp and dwell
    do_reset();
    pulse_save();
    jog_inc[0] = 1'b1;
    repeat (5 * TICK_DIV) step();
    jog_inc[0] = 1'b0;
    chk("pose1_pos", ch(0), 1540);
    pulse_save();
    chk("two_poses", tot, 2);
    model_on = 1'b0;
    pulse_play();
    chk("play_replaying", replaying, 1);
    chk("play_cur", cur, 0);
    for (int t = 1; t <= 5; t++) begin
      next_tick();
      chk("ramp_down", ch(0), 1540 - STEP * t);
    end
    next_tick();
    chk("dwell0_cur", cur, 0);
    chk("dwell0_pos", ch(0), 1500);
    next_tick();
    chk("advance_cur", cur, 1);
    chk("advance_replaying", replaying, 1);
    for (int t = 1; t <= 5; t++) begin
      next_tick();
      chk("ramp_up", ch(0), 1500 + STEP * t);
    end
    next_tick();
    chk("dwell1_replaying", replaying, 1);
    next_tick();
    chk("end_replaying", replaying, 0);
    chk("end_cur", cur, 1);
    chk("end_pos", ch(0), 1540);

    // Loop mode, then stop together with play mid-ramp
    loop_en = 1'b1;
    pulse_play();
    repeat (7) next_tick();
    chk("loop_cur1", cur, 1);
    repeat (7) next_tick();
    chk("loop_wrap_cur", cur, 0);
    chk("loop_wrap_replaying", replaying, 1);
    repeat (2) next_tick();
    chk("loop_mid_ramp", ch(0), 1524);
    step();
    stop = 1'b1; play = 1'b1; step(); stop = 1'b0; play = 1'b0;
    chk("stop_idle", replaying, 0);
    frozen = ch(0);
    repeat (3) next_tick();
    chk("stop_frozen", ch(0), frozen);
    chk("stop_no_restart", replaying, 0);
    loop_en = 1'b0;

    // Reset during REPLAY_MOVE
    pulse_play();
    repeat (2) next_tick();
    chk("pre_rst_replaying", replaying, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N_CH; k++) chk("midrst_center", ch(k), CENTER);
    chk("midrst_tot", tot, 0);
    chk("midrst_replaying", replaying, 0);
    chk("midrst_cur", cur, 0);
    chk("midrst_full", full, 0);
    repeat (2) next_tick();
    chk("post_rst_idle", replaying, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
